// File: rtl/control_acceso_memoria.sv
// Single-port data memory access controller: turns one-shot load/store requests
// from the pipeline into one-cycle memory strobes, with address checks and access counters.
module control_acceso_memoria #(
  parameter int PALABRAS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [31:0] i_dir,
  input  logic [31:0] i_dato,
  output logic        o_ocupado,
  output logic        o_listo,
  output logic        o_error,
  output logic [31:0] o_dato_leido,
  output logic        o_r,
  output logic        o_w,
  output logic [31:0] o_dir_mem,
  output logic [31:0] o_dato_mem,
  input  logic [31:0] i_dato_mem,
  output logic [15:0] o_num_lecturas,
  output logic [15:0] o_num_escrituras
);

  typedef enum logic [1:0] {REPOSO, LEER, ESCRIBIR, FIN} estado_t;

  estado_t     estado_q, estado_d;
  logic        r_q, r_d;
  logic        w_q, w_d;
  logic        listo_q, listo_d;
  logic        error_q, error_d;
  logic [31:0] dir_mem_q, dir_mem_d;
  logic [31:0] dato_mem_q, dato_mem_d;
  logic [31:0] leido_q, leido_d;
  logic [15:0] nlect_q, nlect_d;
  logic [15:0] nescr_q, nescr_d;
  logic        dir_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign dir_ok = (i_dir[1:0] == 2'b00) && ({2'b00, i_dir[31:2]} < 32'(PALABRAS));

  always_comb begin
    estado_d   = estado_q;
    r_d        = 1'b0;
    w_d        = 1'b0;
    listo_d    = 1'b0;
    error_d    = 1'b0;
    dir_mem_d  = dir_mem_q;
    dato_mem_d = dato_mem_q;
    leido_d    = leido_q;
    nlect_d    = nlect_q;
    nescr_d    = nescr_q;
    case (estado_q)
      REPOSO: begin
        if (i_load || i_store) begin
          if ((i_load ^ i_store) && dir_ok) begin
            dir_mem_d = {2'b00, i_dir[31:2]};
            if (i_store) begin
              dato_mem_d = i_dato;
              w_d        = 1'b1;
              estado_d   = ESCRIBIR;
            end else begin
              r_d      = 1'b1;
              estado_d = LEER;
            end
          end else begin
            // Rejected: skip memory entirely and report completion with error.
            listo_d  = 1'b1;
            error_d  = 1'b1;
            estado_d = FIN;
          end
        end
      end
      LEER: begin
        leido_d  = i_dato_mem;
        nlect_d  = sat_inc(nlect_q);
        listo_d  = 1'b1;
        estado_d = FIN;
      end
      ESCRIBIR: begin
        nescr_d  = sat_inc(nescr_q);
        listo_d  = 1'b1;
        estado_d = FIN;
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      estado_q   <= REPOSO;
      r_q        <= 1'b0;
      w_q        <= 1'b0;
      listo_q    <= 1'b0;
      error_q    <= 1'b0;
      dir_mem_q  <= '0;
      dato_mem_q <= '0;
      leido_q    <= '0;
      nlect_q    <= '0;
      nescr_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      r_q        <= r_d;
      w_q        <= w_d;
      listo_q    <= listo_d;
      error_q    <= error_d;
      dir_mem_q  <= dir_mem_d;
      dato_mem_q <= dato_mem_d;
      leido_q    <= leido_d;
      nlect_q    <= nlect_d;
      nescr_q    <= nescr_d;
    end
  end

  assign o_ocupado        = (estado_q != REPOSO);
  assign o_listo          = listo_q;
  assign o_error          = error_q;
  assign o_dato_leido     = leido_q;
  assign o_r              = r_q;
  assign o_w              = w_q;
  assign o_dir_mem        = dir_mem_q;
  assign o_dato_mem       = dato_mem_q;
  assign o_num_lecturas   = nlect_q;
  assign o_num_escrituras = nescr_q;

endmodule

// File: tb/tb_control_acceso_memoria.sv
// Directed bench for control_acceso_memoria with a behavioural memory and a
// completion scoreboard checked on every o_listo pulse.
module tb_control_acceso_memoria;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_load = 1'b0, i_store = 1'b0;
  logic [31:0] i_dir = '0, i_dato = '0;
  logic        o_ocupado, o_listo, o_error, o_r, o_w;
  logic [31:0] o_dato_leido, o_dir_mem, o_dato_mem, i_dato_mem;
  logic [15:0] o_num_lecturas, o_num_escrituras;

  logic [31:0] mem [0:31];

  typedef struct {
    logic        err;
    logic [31:0] dato;
    logic [15:0] nl;
    logic [15:0] ne;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int r_cnt = 0, w_cnt = 0, listo_cnt = 0;
  int r0, w0, l0;

  always #5 clk = ~clk;

  control_acceso_memoria #(.PALABRAS(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_load(i_load), .i_store(i_store),
    .i_dir(i_dir), .i_dato(i_dato), .o_ocupado(o_ocupado), .o_listo(o_listo),
    .o_error(o_error), .o_dato_leido(o_dato_leido), .o_r(o_r), .o_w(o_w),
    .o_dir_mem(o_dir_mem), .o_dato_mem(o_dato_mem), .i_dato_mem(i_dato_mem),
    .o_num_lecturas(o_num_lecturas), .o_num_escrituras(o_num_escrituras)
  );

  assign i_dato_mem = (o_dir_mem < 32'd32) ? mem[o_dir_mem[4:0]] : 32'h0;

  always @(posedge clk) if (o_w === 1'b1 && o_dir_mem < 32'd32) mem[o_dir_mem[4:0]] = o_dato_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic ld, input logic st, input logic [31:0] dir, input logic [31:0] dato);
    i_load = ld; i_store = st; i_dir = dir; i_dato = dato;
    tick();
    i_load = 1'b0; i_store = 1'b0;
  endtask

  task automatic push(input logic err, input logic [31:0] dato, input logic [15:0] nl, input logic [15:0] ne);
    exp_t e;
    e.err = err; e.dato = dato; e.nl = nl; e.ne = ne;
    sb.push_back(e);
  endtask

  // Strobe/pulse counting and scoreboard comparison, away from the active edge.
  always @(negedge clk) begin
    if (o_r === 1'b1) r_cnt++;
    if (o_w === 1'b1) w_cnt++;
    if (o_listo === 1'b1) begin
      exp_t e;
      listo_cnt++;
      chk("listo_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_error", 32'(o_error), 32'(e.err));
        chk("sb_dato_leido", o_dato_leido, e.dato);
        chk("sb_lecturas", 32'(o_num_lecturas), 32'(e.nl));
        chk("sb_escrituras", 32'(o_num_escrituras), 32'(e.ne));
      end
    end
  end

  task automatic chk_reset_state;
    chk("rst_ocupado", 32'(o_ocupado), 32'd0);
    chk("rst_r", 32'(o_r), 32'd0);
    chk("rst_w", 32'(o_w), 32'd0);
    chk("rst_listo", 32'(o_listo), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_dir_mem", o_dir_mem, 32'd0);
    chk("rst_dato_mem", o_dato_mem, 32'd0);
    chk("rst_dato_leido", o_dato_leido, 32'd0);
    chk("rst_lecturas", 32'(o_num_lecturas), 32'd0);
    chk("rst_escrituras", 32'(o_num_escrituras), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[3] = 32'd15;

    // Reset
    i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;
    chk_reset_state();

    // Load hit on word 3
    r0 = r_cnt;
    push(1'b0, 32'd15, 16'd1, 16'd0);
    req(1'b1, 1'b0, 32'h0C, 32'h0);
    chk("ld_r", 32'(o_r), 32'd1);
    chk("ld_w", 32'(o_w), 32'd0);
    chk("ld_dir_mem", o_dir_mem, 32'd3);
    chk("ld_ocupado", 32'(o_ocupado), 32'd1);
    tick();
    chk("ld_fin_r", 32'(o_r), 32'd0);
    chk("ld_fin_listo", 32'(o_listo), 32'd1);
    tick();
    chk("ld_reposo", 32'(o_ocupado), 32'd0);
    chk("ld_listo_off", 32'(o_listo), 32'd0);
    chk("ld_r_cycles", 32'(r_cnt - r0), 32'd1);

    // Store then load at word 4, from a clean reset
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk_reset_state();
    w0 = w_cnt;
    push(1'b0, 32'd0, 16'd0, 16'd1);
    req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("st_w", 32'(o_w), 32'd1);
    chk("st_r", 32'(o_r), 32'd0);
    chk("st_dir_mem", o_dir_mem, 32'd4);
    chk("st_dato_mem", o_dato_mem, 32'hDEADBEEF);
    tick(); tick();
    chk("st_w_cycles", 32'(w_cnt - w0), 32'd1);
    chk("st_mem4", mem[4], 32'hDEADBEEF);
    push(1'b0, 32'hDEADBEEF, 16'd1, 16'd1);
    req(1'b1, 1'b0, 32'h10, 32'h0);
    tick(); tick();

    // Misaligned load: completes on the next cycle with error, no strobes
    r0 = r_cnt; w0 = w_cnt;
    push(1'b1, 32'hDEADBEEF, 16'd1, 16'd1);
    req(1'b1, 1'b0, 32'h06, 32'h0);
    chk("mis_listo", 32'(o_listo), 32'd1);
    chk("mis_error", 32'(o_error), 32'd1);
    tick();
    chk("mis_reposo", 32'(o_ocupado), 32'd0);

    // Out-of-range store (index 32) and load+store conflict
    push(1'b1, 32'hDEADBEEF, 16'd1, 16'd1);
    req(1'b0, 1'b1, 32'h80, 32'h5555_5555);
    chk("oor_error", 32'(o_error), 32'd1);
    tick();
    push(1'b1, 32'hDEADBEEF, 16'd1, 16'd1);
    req(1'b1, 1'b1, 32'h0, 32'h6666_6666);
    chk("conf_error", 32'(o_error), 32'd1);
    tick();
    chk("rej_no_r", 32'(r_cnt - r0), 32'd0);
    chk("rej_no_w", 32'(w_cnt - w0), 32'd0);
    chk("rej_mem0", mem[0], 32'h1000_0000);

    // Last valid word (index 31): store then load
    push(1'b0, 32'hDEADBEEF, 16'd1, 16'd2);
    req(1'b0, 1'b1, 32'h7C, 32'h1234_5678);
    chk("top_dir_mem", o_dir_mem, 32'd31);
    tick(); tick();
    push(1'b0, 32'h1234_5678, 16'd2, 16'd2);
    req(1'b1, 1'b0, 32'h7C, 32'h0);
    tick(); tick();

    // Reset during LEER
    l0 = listo_cnt;
    req(1'b1, 1'b0, 32'h0C, 32'h0);
    chk("rmr_r_before", 32'(o_r), 32'd1);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk_reset_state();
    tick(); tick(); tick();
    chk("rmr_no_listo", 32'(listo_cnt - l0), 32'd0);
    chk("rmr_lecturas", 32'(o_num_lecturas), 32'd0);

    // Second load held through LEER and FIN of the first one is ignored
    l0 = listo_cnt;
    push(1'b0, 32'd15, 16'd1, 16'd0);
    i_load = 1'b1; i_dir = 32'h0C;
    tick();
    i_dir = 32'h10;
    tick();
    tick();
    i_load = 1'b0;
    chk("busy_reposo", 32'(o_ocupado), 32'd0);
    tick(); tick(); tick();
    chk("busy_one_listo", 32'(listo_cnt - l0), 32'd1);
    chk("busy_lecturas", 32'(o_num_lecturas), 32'd1);
    chk("busy_dato", o_dato_leido, 32'd15);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
